// File: rtl/i2s_transmitter.sv
// I2S master transmitter: BCLK/LRCK generation, frame latch strobe, 18-bit serializer.
// Define I2S_LEFT_JUSTIFIED_EN for left-justified output with inverted LRCK.
module i2s_transmitter #(
  parameter int BCLK_DIV  = 4,
  parameter int SLOT_BITS = 32,
  parameter int DATA_BITS = 18
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [DATA_BITS-1:0] i_left,
  input  logic [DATA_BITS-1:0] i_right,
  output logic                 o_latch,
  output logic                 o_bclk,
  output logic                 o_lrck,
  output logic                 o_sdata
);

  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BW = $clog2(2 * SLOT_BITS);
  localparam logic [DW-1:0] DIV_TC = DW'(BCLK_DIV - 1);
  localparam logic [BW-1:0] B_LAST = BW'(2 * SLOT_BITS - 1);

`ifdef I2S_LEFT_JUSTIFIED_EN
  localparam logic LRCK_RST = 1'b0;
`else
  localparam logic LRCK_RST = 1'b1;
`endif

  logic [DW-1:0]        div;
  logic [BW-1:0]        b;
  logic [BW-1:0]        b_nxt;
  logic [DATA_BITS-1:0] hold_l;
  logic [DATA_BITS-1:0] hold_r;
  logic [DATA_BITS-1:0] word;
  logic [DATA_BITS-1:0] mask;
  logic                 tc;
  logic                 rise;
  logic                 fall;
  logic                 wrap;
  logic                 right;
  logic                 lrck_nxt;
  logic                 sdata_nxt;
  int                   p;
  int                   shamt;

  always_comb begin
    tc    = (div == DIV_TC);
    rise  = tc && !o_bclk;
    fall  = tc && o_bclk;
    wrap  = (b == B_LAST);
    b_nxt = wrap ? '0 : b + BW'(1);
    right = (int'(b_nxt) >= SLOT_BITS);
    p     = right ? int'(b_nxt) - SLOT_BITS : int'(b_nxt);
    // On the wrap edge the left word is being captured, so use it directly.
    word  = wrap ? i_left : (right ? hold_r : hold_l);
`ifdef I2S_LEFT_JUSTIFIED_EN
    lrck_nxt  = !right;
    shamt     = (p < DATA_BITS) ? DATA_BITS - 1 - p : 0;
    mask      = DATA_BITS'(1) << shamt;
    sdata_nxt = (p < DATA_BITS) && |(word & mask);
`else
    lrck_nxt  = right;
    shamt     = (p >= 1 && p <= DATA_BITS) ? DATA_BITS - p : 0;
    mask      = DATA_BITS'(1) << shamt;
    sdata_nxt = (p >= 1 && p <= DATA_BITS) && |(word & mask);
`endif
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      div     <= '0;
      o_bclk  <= 1'b0;
      o_lrck  <= LRCK_RST;
      o_sdata <= 1'b0;
      o_latch <= 1'b0;
      b       <= B_LAST;
      hold_l  <= '0;
      hold_r  <= '0;
    end else begin
      o_latch <= rise && wrap;
      if (tc) begin
        div    <= '0;
        o_bclk <= ~o_bclk;
      end else begin
        div <= div + DW'(1);
      end
      if (fall) begin
        b       <= b_nxt;
        o_lrck  <= lrck_nxt;
        o_sdata <= sdata_nxt;
        if (wrap) begin
          hold_l <= i_left;
          hold_r <= i_right;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_transmitter.sv
// Bench for i2s_transmitter: default instance plus a BCLK_DIV=2, SLOT_BITS=24 instance,
// both checked every cycle against a frame-arithmetic model.
module tb_i2s_transmitter;

  localparam int D    = 18;
  localparam int DIV0 = 4;
  localparam int S0   = 32;
  localparam int DIV1 = 2;
  localparam int S1   = 24;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [D-1:0] left = '0;
  logic [D-1:0] right = '0;
  logic latch0, bclk0, lrck0, sd0;
  logic latch1, bclk1, lrck1, sd1;

  i2s_transmitter dut0 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_left(left), .i_right(right),
    .o_latch(latch0), .o_bclk(bclk0),
    .o_lrck(lrck0), .o_sdata(sd0)
  );

  i2s_transmitter #(
    .BCLK_DIV(DIV1), .SLOT_BITS(S1), .DATA_BITS(D)
  ) dut1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_left(left), .i_right(right),
    .o_latch(latch1), .o_bclk(bclk1),
    .o_lrck(lrck1), .o_sdata(sd1)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int n = 0;
  bit started = 0;
  bit first_run = 1;
  logic [D-1:0] cap_l [2][64];
  logic [D-1:0] cap_r [2][64];

  task automatic check(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at n=%0d: got %b expected %b", name, n, act, exp);
    end
  endtask

  // Frame index captured at clock count nn, or -1 if nn is not a capture clock.
  function automatic int cap_frame(int div, int s, int nn);
    int k;
    if (nn == 0 || nn % (2 * div) != 0) return -1;
    k = nn / (2 * div);
    if ((k - 1) % (2 * s) != 0) return -1;
    return (k - 1) / (2 * s);
  endfunction

  // Expected {latch, bclk, lrck, sdata} nn clocks after reset release.
  function automatic logic [3:0] model(int inst, int div, int s, int nn);
    int h, k, b, p, f;
    logic lat, bc, lr, sd;
    logic [D-1:0] w;
    h   = nn / div;
    bc  = (h % 2) == 1;
    lat = (nn > 0) && (nn % div == 0) && (h % 2 == 1) && ((h / 2) % (2 * s) == 0);
    k   = nn / (2 * div);
    lr  = 1'b1;
    sd  = 1'b0;
    if (k > 0) begin
      b  = (k - 1) % (2 * s);
      f  = (k - 1) / (2 * s);
      lr = (b >= s);
      p  = b % s;
      w  = '0;
      if (f < 64) w = lr ? cap_r[inst][f] : cap_l[inst][f];
      if (p >= 1 && p <= D) sd = ((w >> (D - p)) & 1) != 0;
    end
    return {lat, bc, lr, sd};
  endfunction

  always @(posedge clk) begin
    int f;
    started = 1;
    if (!rst_n) n = 0;
    else n = n + 1;
    f = cap_frame(DIV0, S0, n);
    if (f >= 0 && f < 64) begin
      cap_l[0][f] = left;
      cap_r[0][f] = right;
    end
    f = cap_frame(DIV1, S1, n);
    if (f >= 0 && f < 64) begin
      cap_l[1][f] = left;
      cap_r[1][f] = right;
    end
  end

  always @(negedge clk) begin
    logic [3:0] e0, e1;
    if (started) begin
      e0 = model(0, DIV0, S0, n);
      e1 = model(1, DIV1, S1, n);
      check("d0_latch", latch0, e0[3]);
      check("d0_bclk", bclk0, e0[2]);
      check("d0_lrck", lrck0, e0[1]);
      check("d0_sdata", sd0, e0[0]);
      check("d1_latch", latch1, e1[3]);
      check("d1_bclk", bclk1, e1[2]);
      check("d1_lrck", lrck1, e1[1]);
      check("d1_sdata", sd1, e1[0]);
      if (first_run) begin
        case (n)
          2: begin
            check("lit_d1_latch_first", latch1, 1'b1);
            check("lit_d1_bclk_first", bclk1, 1'b1);
          end
          3: begin
            check("lit_d0_bclk_pre", bclk0, 1'b0);
            check("lit_d0_latch_pre", latch0, 1'b0);
          end
          4: begin
            check("lit_d0_latch_first", latch0, 1'b1);
            check("lit_d0_bclk_first", bclk0, 1'b1);
            check("lit_d1_lrck_fall", lrck1, 1'b0);
          end
          5: check("lit_d0_latch_width", latch0, 1'b0);
          7: check("lit_d0_lrck_pre", lrck0, 1'b1);
          8: begin
            check("lit_d0_lrck_fall", lrck0, 1'b0);
            check("lit_d0_p0", sd0, 1'b0);
          end
          16: check("lit_left_p1", sd0, 1'b1);
          20: check("lit_left_p1_hold", sd0, 1'b1);
          24: check("lit_left_p2", sd0, 1'b0);
          99: check("lit_d1_lrck_left", lrck1, 1'b0);
          100: check("lit_d1_lrck_right", lrck1, 1'b1);
          144: check("lit_left_p17", sd0, 1'b1);
          152: check("lit_left_p18", sd0, 1'b0);
          160: check("lit_left_p19", sd0, 1'b0);
          194: check("lit_d1_latch_frame", latch1, 1'b1);
          264: begin
            check("lit_right_lrck", lrck0, 1'b1);
            check("lit_right_p0", sd0, 1'b0);
          end
          272: check("lit_right_p1", sd0, 1'b0);
          280: check("lit_right_p2", sd0, 1'b1);
          515: check("lit_d0_latch_pre2", latch0, 1'b0);
          516: check("lit_d0_latch_frame", latch0, 1'b1);
          default: ;
        endcase
      end
    end
  end

  initial begin
    bit seen;
    rst_n = 1'b0;
    left  = 18'h2AAAA;
    right = 18'h15555;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    seen = 0;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(negedge clk);
      if (latch0) seen = 1;
    end
    check("latch_timeout", seen, 1'b1);
    left  = 18'h12345;
    right = 18'h0ABCD;
    repeat (3) @(negedge clk);
    left  = 18'h0F0F0;
    right = 18'h30303;
    repeat (40) @(negedge clk);
    left  = 18'h3FFFF;
    right = 18'h00001;
    repeat (350) @(negedge clk);
    first_run = 0;
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_latch", latch0, 1'b0);
    check("rst_bclk", bclk0, 1'b0);
    check("rst_lrck", lrck0, 1'b1);
    check("rst_sdata", sd0, 1'b0);
    rst_n = 1'b1;
    repeat (1200) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/i2s_transmitter.md
Name: i2s_transmitter

Overview:
- Downstream consumer of the per-channel 18-bit sample latch stage.
- Generates I2S master timing (BCLK, LRCK) from the system clock and serializes one left and one right 18-bit sample per frame onto SDATA.
- Emits a one-clock latch strobe that commands the upstream latches to present the next frame's samples.
- Both channels are captured together at frame start.

Parameters:
BCLK_DIV, 4, system clocks per BCLK half-period; legal range >= 2
SLOT_BITS, 32, BCLK cycles per channel slot; legal range >= DATA_BITS+1
DATA_BITS, 18, sample width, MSB first

Ports:
i_clk  input  1  system clock; all logic on rising edge
i_rst_n  input  1  synchronous reset, active low
i_left  input  DATA_BITS  left sample, two's complement
i_right  input  DATA_BITS  right sample, two's complement
o_latch  output  1  one-clock pulse requesting the next frame's samples
o_bclk  output  1  I2S bit clock
o_lrck  output  1  I2S word select; 0 = left, 1 = right
o_sdata  output  1  I2S serial data, changes only when o_bclk falls

Behaviour:
- Reset (i_rst_n low at a clock edge):
  - div counter = 0, o_bclk = 0, o_lrck = 1, o_sdata = 0, o_latch = 0.
  - Bit index b = 2*SLOT_BITS-1; holding registers = 0.
  - Reset mid-frame aborts the frame immediately; no partial-word completion.
- Divider:
  - Counter runs 0..BCLK_DIV-1. At terminal count, o_bclk toggles and the counter wraps to 0.
  - BCLK period = 2*BCLK_DIV clocks; duty cycle 50%.
- Rising-edge event (clock where o_bclk goes 0->1):
  - If b == 2*SLOT_BITS-1, o_latch = 1 for exactly this clock; otherwise o_latch = 0.
  - The upstream latch updates on this clock, so samples are stable on the following clock.
- Falling-edge event (clock where o_bclk goes 1->0):
  - b advances: b = (b == 2*SLOT_BITS-1) ? 0 : b+1.
  - When b wraps to 0: i_left and i_right are captured into holding registers L and R.
    - The capture happens BCLK_DIV clocks after o_latch, which is why BCLK_DIV >= 2.
    - The captured values are held unchanged for the whole frame.
  - o_lrck = 0 for b in [0, SLOT_BITS); 1 for b in [SLOT_BITS, 2*SLOT_BITS).
  - Slot position p = b mod SLOT_BITS; word W = L for the left slot, R for the right slot.
  - o_sdata = W[DATA_BITS-p] for p in 1..DATA_BITS; 0 for p = 0 and p > DATA_BITS.
    - This is the standard I2S one-BCLK delay, MSB first, zero padding.
- All outputs are registered; nothing is combinational from the inputs.
- Frame length = 2*SLOT_BITS*2*BCLK_DIV clocks (512 at defaults).
- First frame after reset:
  - o_latch pulses BCLK_DIV clocks after reset release (first rising edge).
  - The first falling edge starts b = 0.
- i_left and i_right may change at any time; only the value present at the capture clock is used.

Optional Feature:
Macro I2S_LEFT_JUSTIFIED_EN.
- Defined:
  - Left-justified format: no one-bit delay.
  - o_sdata = W[DATA_BITS-1-p] for p in 0..DATA_BITS-1, else 0.
  - LRCK polarity inverted: 1 = left, 0 = right.
  - Reset value of o_lrck = 0.
  - Latch and capture timing are unchanged.
- Undefined: standard I2S as above.

Test Plan:
1. Reset release, defaults -> o_bclk first rises 4 clks after release; o_latch high for exactly that 1 clk; o_lrck falls 4 clks later; then 512-clk frame period; o_latch recurs every 512 clks, always 1 clk wide.
2. i_left=18'h2AAAA, i_right=18'h15555 held -> on o_bclk rising edges sample the bits:
   - p=0: 0.
   - Left p=1..18 reads 1,0,1,0,...; right reads 0,1,0,1,...
   - p=19..31: 0.
   - o_sdata never changes while o_bclk is high.
3. Inputs changed 1 clk after o_latch vs 1 clk before capture -> the value present at the capture clock is serialized; a change mid-frame does not alter the current frame's bits.
4. i_rst_n pulled low for 1 clk mid-right-slot -> next clock all outputs at reset values; timing restarts exactly as in scenario 1.
5. BCLK_DIV=2, SLOT_BITS=24 -> BCLK period 4 clks; frame 192 clks; LRCK toggles every 96 clks; left=18'h3FFFF gives 18 ones at p=1..18, then 5 zeros.
6. I2S_LEFT_JUSTIFIED_EN defined, i_left=18'h20000, i_right=0 -> o_sdata=1 only at left p=0; o_lrck high during the left slot; o_lrck=0 after reset.
